alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_op_sequencer_if.sv | 31 +++
 rtl/alu_op_sequencer_mul3.sv | 50 +++++
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode/state types and overflow bounds for the ALU operation sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_UMUL = 2'b10,
        OP_SMUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int OVF_MIN = -4;
    localparam int OVF_MAX = 3;

    localparam int unsigned ID_W = 1;

    // Magnitude of a 3-bit two's complement value; -4 maps to 3'b100 (4).
    function automatic logic [2:0] abs3(input logic [2:0] v);
        return v[2] ? (~v + 3'd1) : v;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/result bus between requesters (master) and the ALU sequencer (slave).
interface alu_op_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned W_OP  = 3,
    parameter int unsigned W_RES = 6
) ();

    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_op;
    logic [W_OP*NREQ-1:0] req_a;
    logic [W_OP*NREQ-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 busy;
    logic                 res_valid;
    logic [W_RES-1:0]     res_data;
    logic                 res_ovf;
    logic [ID_W-1:0]      res_id;

    modport master (
        output req_valid, req_op, req_a, req_b,
        input  req_ready, busy, res_valid, res_data, res_ovf, res_id
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        output req_ready, busy, res_valid, res_data, res_ovf, res_id
    );

endinterface

// File: rtl/alu_op_sequencer_mul3.sv
// Three-iteration unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
module shift_add_mul3 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [2:0] mcand_i,
    input  logic [2:0] mplier_i,
    output logic       done_o,
    output logic [5:0] product_o
);

    logic       run_q;
    logic [1:0] cnt_q;
    logic [5:0] acc_q, acc_d;
    logic [5:0] mcand_q;
    logic [2:0] mplier_q;

    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : 6'd0);
    end

    // The final partial sum is presented during the last iteration so the caller can capture it.
    assign done_o    = run_q && (cnt_q == 2'd2);
    assign product_o = acc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {3'b000, mcand_i};
            mplier_q <= mplier_i;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[4:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[2:1]};
            cnt_q    <= cnt_q + 2'd1;
            if (cnt_q == 2'd2) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Round-robin arbitrated add/sub/mul sequencer: IDLE grants, EXEC computes, DONE strobes the result.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned W_OP  = 3,
    parameter int unsigned W_RES = 6
) (
    input logic                clk_2,
    input logic                reset,
    alu_op_sequencer_if.slave  bus
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [W_OP-1:0]   a_q, b_q;
    logic [ID_W-1:0]   id_q, last_q;
    logic              neg_q;
    logic [W_RES-1:0]  res_data_q;
    logic              res_ovf_q;
    logic [ID_W-1:0]   res_id_q;

    logic              any_valid;
    int unsigned       cand, grant_idx;
    logic [NREQ-1:0]   valid_sh;
    logic [ID_W-1:0]   grant_id;
    op_e               sel_op;
    logic [W_OP-1:0]   sel_a, sel_b;
    logic              grant;

    logic              mul_start, mul_done;
    logic [5:0]        mul_prod;

    logic signed [W_OP+1:0] a_ext, b_ext, as_full;
    logic [W_RES-1:0]  exec_data;
    logic              exec_ovf;

    // Search starts one past the last granted requester.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = 0;
        cand      = 0;
        valid_sh  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand     = (32'(last_q) + k) % NREQ;
            valid_sh = bus.req_valid >> cand;
            if (!any_valid && valid_sh[0]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
        grant_id = ID_W'(grant_idx);
        sel_op   = op_e'(2'(bus.req_op >> (2 * grant_idx)));
        sel_a    = W_OP'(bus.req_a >> (grant_idx * W_OP));
        sel_b    = W_OP'(bus.req_b >> (grant_idx * W_OP));
        grant    = (state_q == IDLE) && any_valid;
    end

    assign mul_start = grant && sel_op[1];

    shift_add_mul3 u_mul (
        .clk_i     (clk_2),
        .rst_i     (reset),
        .start_i   (mul_start),
        .mcand_i   ((sel_op == OP_SMUL) ? abs3(sel_a) : sel_a),
        .mplier_i  ((sel_op == OP_SMUL) ? abs3(sel_b) : sel_b),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        a_ext     = (W_OP+2)'(signed'(a_q));
        b_ext     = (W_OP+2)'(signed'(b_q));
        as_full   = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        exec_ovf  = 1'b0;
        exec_data = '0;
        if (op_q[1]) begin
            exec_data = neg_q ? (W_RES'(0) - W_RES'(mul_prod)) : W_RES'(mul_prod);
        end else begin
            exec_data = W_RES'(signed'(as_full[W_OP-1:0]));
            exec_ovf  = (as_full < (W_OP+2)'(OVF_MIN)) || (as_full > (W_OP+2)'(OVF_MAX));
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid) state_d = EXEC;
            EXEC:    if (!op_q[1] || mul_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.res_valid = (state_q == DONE);
        bus.req_ready = grant ? (NREQ'(1) << grant_idx) : '0;
        bus.res_data  = res_data_q;
        bus.res_ovf   = res_ovf_q;
        bus.res_id    = res_id_q;
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            op_q       <= OP_ADD;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            last_q     <= ID_W'(NREQ - 1);
            neg_q      <= 1'b0;
            res_data_q <= '0;
            res_ovf_q  <= 1'b0;
            res_id_q   <= '0;
        end else begin
            if (grant) begin
                op_q   <= sel_op;
                a_q    <= sel_a;
                b_q    <= sel_b;
                id_q   <= grant_id;
                last_q <= grant_id;
                neg_q  <= (sel_op == OP_SMUL) && (sel_a[W_OP-1] ^ sel_b[W_OP-1]);
            end
            if ((state_q == EXEC) && (state_d == DONE)) begin
                res_data_q <= exec_data;
                res_ovf_q  <= exec_ovf;
                res_id_q   <= id_q;
            end
        end
    end

endmodule
